// File: rtl/serv_seq_pkg.sv
// Shared definitions for the SERV execution sequencer.
// Covers the FSM state encoding and the geometry of the bit-serial count window.
package serv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_RFWAIT = 3'd3,
    S_RUN    = 3'd4
  } seq_state_e;

  localparam int CNT_W    = 5;
  localparam int CNT_LAST = 31;

endpackage

// File: rtl/serv_exec_cnt.sv
// Bit index and pass counters for the serial execution window.
// The pass limit is latched once per instruction and saturated to the configured maximum.
module serv_exec_cnt
  import serv_seq_pkg::*;
#(
  parameter int MAX_PASSES = 4,
  parameter int PASS_W     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [PASS_W-1:0] i_passes,
  input  logic              i_adv,
  output logic [CNT_W-1:0]  o_cnt,
  output logic [PASS_W-1:0] o_pass,
  output logic              o_cnt_last,
  output logic              o_last_pass
);

  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(MAX_PASSES - 1);
  localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(CNT_LAST);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] passMax_q, passMax_d;

  assign o_cnt       = cnt_q;
  assign o_pass      = pass_q;
  assign o_cnt_last  = (cnt_q == CNT_END);
  assign o_last_pass = (pass_q == passMax_q);

  // The bit index wraps on its own; the pass index only moves on the last bit and
  // returns to zero once the final pass completes.
  always_comb begin
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    passMax_d = passMax_q;
    if (i_load) begin
      passMax_d = (i_passes > PASS_MAX) ? PASS_MAX : i_passes;
    end
    if (i_clear) begin
      cnt_d  = '0;
      pass_d = '0;
    end else if (i_adv) begin
      cnt_d = cnt_q + 1'b1;
      if (o_cnt_last) begin
        pass_d = o_last_pass ? '0 : pass_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      pass_q    <= '0;
      passMax_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      passMax_q <= passMax_d;
    end
  end

endmodule

// File: rtl/serv_exec_seq.sv
// Bit-serial execution sequencer: fetch, decode strobe, RF request and the 32-cycle count window.
// Build option SERV_EXEC_SEQ_STALL_EN makes i_stall pause the count window; otherwise it is ignored.
module serv_exec_seq
  import serv_seq_pkg::*;
#(
  parameter int MAX_PASSES = 4,
  parameter int PASS_W     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_ibus_cyc,
  input  logic              i_ibus_ack,
  output logic              o_wb_en,
  input  logic [PASS_W-1:0] i_passes,
  output logic              o_rf_rreq,
  input  logic              i_rf_ready,
  input  logic              i_stall,
  output logic              o_cnt_en,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_cnt0,
  output logic              o_cnt_done,
  output logic [PASS_W-1:0] o_pass,
  output logic              o_last_pass,
  output logic              o_instr_done
);

  seq_state_e state_q, state_d;
  logic       instrDone_q, instrDone_d;
  logic       stallEff;
  logic       cntEn;
  logic       cntLast;

`ifdef SERV_EXEC_SEQ_STALL_EN
  assign stallEff = i_stall;
`else
  logic unusedStall;
  assign unusedStall = i_stall;
  assign stallEff    = 1'b0;
`endif

  serv_exec_cnt #(
    .MAX_PASSES (MAX_PASSES),
    .PASS_W     (PASS_W)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (state_q != S_RUN),
    .i_load      (state_q == S_DECODE),
    .i_passes    (i_passes),
    .i_adv       (cntEn),
    .o_cnt       (o_cnt),
    .o_pass      (o_pass),
    .o_cnt_last  (cntLast),
    .o_last_pass (o_last_pass)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      instrDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instrDone_q <= instrDone_d;
    end
  end

  // Passes run back to back inside RUN; only the last bit of the last pass leaves it.
  always_comb begin
    state_d     = state_q;
    instrDone_d = cntEn & cntLast & o_last_pass;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (i_ibus_ack) state_d = S_DECODE;
      S_DECODE: state_d = S_RFWAIT;
      S_RFWAIT: if (i_rf_ready) state_d = S_RUN;
      S_RUN:    if (instrDone_d) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ibus_cyc = 1'b0;
    o_rf_rreq  = 1'b0;
    cntEn      = 1'b0;
    case (state_q)
      S_FETCH:  o_ibus_cyc = 1'b1;
      S_DECODE: o_rf_rreq  = 1'b1;
      S_RUN:    cntEn      = ~stallEff;
      default:  ;
    endcase
  end

  assign o_wb_en      = o_ibus_cyc & i_ibus_ack;
  assign o_cnt_en     = cntEn;
  assign o_cnt0       = cntEn & (o_cnt == '0);
  assign o_cnt_done   = cntEn & cntLast;
  assign o_instr_done = instrDone_q;

endmodule
